// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CNT_W = 16;
endpackage

// File: rtl/hazard_controller_sat_counter.sv
// sat_counter: up counter that sticks at its all-ones maximum
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, memory-wait freeze and branch flush sequencer
module hazard_controller #(
  parameter int CNT_W    = hazard_pkg::CNT_W,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_pkg::*;
  localparam int WW = $clog2(WAIT_MAX + 1);
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic lu, ms, hold;
  always_comb begin
    lu = ex_mem_read && ex_rt != REG_ZERO && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    ms = mem_req && !mem_ready;
    hold = state == TIMEOUT || (state == MEM_WAIT ? !mem_ready : ms);
    pc_write = !rst && !hold && !lu;
    if_id_write = pc_write;
    if_id_flush = rst || (!hold && !lu && branch_taken);
    id_ex_bubble = rst || (!hold && lu);
    pipe_hold = !rst && hold;
    mem_timeout = !rst && state == TIMEOUT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
    end else if (state == RUN) begin
      if (ms) begin
        state <= WAIT_MAX == 1 ? TIMEOUT : MEM_WAIT;
        wait_cnt <= WW'(1);
      end
    end else if (state == MEM_WAIT) begin
      if (mem_ready) begin
        state <= RUN;
        wait_cnt <= '0;
      end else if (wait_cnt >= WW'(WAIT_MAX - 1)) state <= TIMEOUT;
      else wait_cnt <= wait_cnt + WW'(1);
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!pc_write), .count(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(if_id_flush), .count(flush_cnt));
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench with hand-computed per-cycle expectations
module tb_hazard_controller;
  localparam int CW = 2;
  logic clk = 1'b1;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  typedef struct packed {
    logic [5:0]    c;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          cc;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  hazard_controller #(.CNT_W(CW), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout};
      checks++;
      if (got !== e.c) begin
        failures++;
        $display("FAIL cyc%0d ctrl{pc,ifw,flush,bubble,hold,timeout} got %b exp %b", cyc_n, got, e.c);
      end
      if (e.cc) begin
        checks += 2;
        if (stall_cnt !== e.sc) begin
          failures++;
          $display("FAIL cyc%0d stall_cnt got %0d exp %0d", cyc_n, stall_cnt, e.sc);
        end
        if (flush_cnt !== e.fc) begin
          failures++;
          $display("FAIL cyc%0d flush_cnt got %0d exp %0d", cyc_n, flush_cnt, e.fc);
        end
      end
      cyc_n++;
    end
  task automatic cyc(input logic [5:0] c, input int sc, input int fc, input bit cc = 1'b1);
    q.push_back('{c: c, sc: CW'(sc), fc: CW'(fc), cc: cc});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int sc, input int fc);
    rst = 1'b1;
    cyc(6'b001100, sc, fc);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    {id_rs, id_rt, ex_rt} = '0;
    {id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready} = '0;
    cyc(6'b001100, 0, 0, 1'b0);
    cyc(6'b001100, 0, 0);
    rst = 1'b0;
    cyc(6'b110000, 0, 0);
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    cyc(6'b000100, 0, 0);
    ex_mem_read = 0;
    cyc(6'b110000, 1, 0);
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    cyc(6'b110000, 1, 0);
    ex_rt = 7; id_rt = 7; id_rs = 3; id_uses_rt = 0;
    cyc(6'b110000, 1, 0);
    id_uses_rt = 1;
    cyc(6'b000100, 1, 0);
    ex_mem_read = 0; id_uses_rt = 0;
    cyc(6'b110000, 2, 0);
    do_reset(2, 0);
    mem_req = 1; mem_ready = 0;
    cyc(6'b000010, 0, 0);
    cyc(6'b000010, 1, 0);
    cyc(6'b000010, 2, 0);
    mem_ready = 1;
    cyc(6'b110000, 3, 0);
    mem_req = 0; mem_ready = 0;
    cyc(6'b110000, 3, 0);
    do_reset(3, 0);
    mem_req = 1; branch_taken = 1;
    cyc(6'b000010, 0, 0);
    cyc(6'b000010, 1, 0);
    mem_ready = 1;
    cyc(6'b111000, 2, 0);
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    cyc(6'b110000, 2, 1);
    mem_req = 1; ex_mem_read = 1; ex_rt = 9; id_rs = 9; branch_taken = 1;
    cyc(6'b000010, 2, 1);
    mem_ready = 1;
    cyc(6'b000100, 3, 1);
    ex_mem_read = 0; mem_req = 0; mem_ready = 0;
    cyc(6'b111000, 3, 1);
    branch_taken = 0;
    cyc(6'b110000, 3, 2);
    ex_mem_read = 1; branch_taken = 1;
    cyc(6'b000100, 3, 2);
    ex_mem_read = 0; branch_taken = 0;
    cyc(6'b110000, 3, 2);
    do_reset(3, 2);
    mem_req = 1;
    cyc(6'b000010, 0, 0);
    cyc(6'b000010, 1, 0);
    cyc(6'b000010, 2, 0);
    cyc(6'b000010, 3, 0);
    cyc(6'b000011, 3, 0);
    mem_req = 0;
    cyc(6'b000011, 3, 0);
    mem_ready = 1;
    cyc(6'b000011, 3, 0);
    mem_ready = 0;
    do_reset(3, 0);
    cyc(6'b110000, 0, 0);
    branch_taken = 1;
    cyc(6'b111000, 0, 0);
    cyc(6'b111000, 0, 1);
    cyc(6'b111000, 0, 2);
    cyc(6'b111000, 0, 3);
    cyc(6'b111000, 0, 3);
    branch_taken = 0;
    cyc(6'b110000, 0, 3);
    mem_req = 1;
    cyc(6'b000010, 0, 3);
    do_reset(1, 3);
    mem_req = 0;
    cyc(6'b110000, 0, 0);
    mem_req = 1;
    cyc(6'b000010, 0, 0);
    cyc(6'b000010, 1, 0);
    cyc(6'b000010, 2, 0);
    cyc(6'b000010, 3, 0);
    cyc(6'b000011, 3, 0);
    mem_req = 0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline stall/flush sequencer for the 5-stage MIPS datapath, sitting beside the forwarding unit in the ID/EX boundary logic. Detects load-use hazards that forwarding cannot cover, freezes the pipeline while the multi-cycle data memory is busy, and squashes the IF/ID instruction on a taken branch. It keeps saturating stall and flush counters for performance debug, and flags a sticky timeout if memory never answers.

## Interface
- CNT_W, 16, width of the stall/flush performance counters
- WAIT_MAX, 255, maximum memory-wait cycles before timeout (≥1)
- clk  input  1  rising-edge clock; one clock for the whole block
- rst  input  1  synchronous, active-high reset
- id_rs  input  5  Rs of instruction in ID
- id_rt  input  5  Rt of instruction in ID
- id_uses_rt  input  1  ID instruction reads Rt as a source
- ex_rt  input  5  destination (Rt) of instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- branch_taken  input  1  branch in ID resolved taken
- mem_req  input  1  MEM stage instruction accesses data memory
- mem_ready  input  1  data memory completes access this cycle
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_bubble  output  1  load NOP into ID/EX
- pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB
- mem_timeout  output  1  sticky memory timeout flag
- stall_cnt  output  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  output  CNT_W  cycles with if_id_flush=1, saturating

## Operation
- States: RUN, MEM_WAIT, TIMEOUT. Reset state RUN.
- Load-use hazard (lu) = ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- mem_stall (ms) = mem_req & !mem_ready.
- RUN, priority ms > lu > branch:
  - ms: pc_write=0, if_id_write=0, pipe_hold=1, no flush, no bubble; next MEM_WAIT, wait counter ← 1.
  - else lu: pc_write=0, if_id_write=0, id_ex_bubble=1, flush suppressed; stay RUN.
  - else branch_taken: if_id_flush=1, pc_write=1; stay RUN.
  - else all enables 1, flush/bubble/hold 0.
- MEM_WAIT: while !mem_ready: full hold as above, wait counter +1; when the counter reaches WAIT_MAX with mem_ready still 0, next TIMEOUT. On mem_ready=1: hold released that same cycle, and lu/branch are evaluated exactly as in RUN; next RUN.
- TIMEOUT: full hold forever, mem_timeout=1; left only by rst.
- Counters: stall_cnt +1 on every cycle with pc_write=0 (incl. TIMEOUT); flush_cnt +1 per flush cycle; both stick at 2^CNT_W−1.
- A taken branch during a hold is not lost: ID is frozen, so branch_taken is still presented and flushes on the release cycle.

## Timing
- Control outputs (pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold) are combinational from state and inputs, with zero-cycle latency. State, wait counter, counters and mem_timeout are registered.
- While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0, mem_timeout=0. Next edge: state=RUN, stall_cnt=0, flush_cnt=0, wait counter=0.
- rst mid-MEM_WAIT or in TIMEOUT returns to RUN on the next edge; no pending state survives.
- A load-use stall lasts exactly 1 cycle; the bubble clears the hazard.
- A memory stall of N cycles (mem_ready low for N cycles) gives N cycles of pc_write=0.
- Timeout: the cycle after WAIT_MAX consecutive wait cycles shows mem_timeout=1.

## Structure
- Shared package hazard_pkg: state enum {RUN, MEM_WAIT, TIMEOUT}, REG_ZERO=5'd0, default CNT_W.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice. The wait counter is local.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 → one cycle pc_write=0, id_ex_bubble=1, stall_cnt=1; same with ex_rt=0 → no stall.
- Rt gating: ex_rt=7=id_rt with id_uses_rt=0 → no stall; id_uses_rt=1 → stall.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high → pipe_hold=1 for 3 cycles, released on the ready cycle, stall_cnt=3.
- Branch during wait: branch_taken=1 throughout a 2-cycle wait → no flush while held, if_id_flush=1 on the release cycle, flush_cnt=1.
- Timeout: WAIT_MAX=4, mem_ready never rises → TIMEOUT, mem_timeout=1, hold stays; rst for 1 cycle → RUN, counters 0.
- Saturation: CNT_W=2, hold 6 stall cycles → stall_cnt=3.
